// File: rtl/list_walker.sv
// list_walker: walks a cons-cell chain through memory_unit, streaming car values until cdr == NIL.
// Optional length limit enabled by defining LIST_WALKER_LEN_LIMIT_EN (abort at MAX_LEN with error).
`default_nettype none

module list_walker #(
  parameter int                DATA_W  = 24,
  parameter logic [DATA_W-1:0] NIL     = '0,
  parameter int                LEN_W   = 16,
  parameter int                MAX_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] head_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [LEN_W-1:0]  length_o,
  output logic              elem_valid_o,
  output logic [DATA_W-1:0] elem_data_o,
  input  logic              elem_ready_i,
  output logic              mem_car_o,
  output logic              mem_cdr_o,
  output logic              mem_cons_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  input  logic              mem_ready_i
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_REQ_CAR  = 4'd1,
    S_GRD_CAR  = 4'd2,
    S_WAIT_CAR = 4'd3,
    S_EMIT     = 4'd4,
    S_REQ_CDR  = 4'd5,
    S_GRD_CDR  = 4'd6,
    S_WAIT_CDR = 4'd7,
    S_FIN      = 4'd8
  } state_t;

`ifdef LIST_WALKER_LEN_LIMIT_EN
  localparam logic [LEN_W:0] LIMIT = (LEN_W+1)'(MAX_LEN);
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic                elem_valid_q, elem_valid_d;
  logic [DATA_W-1:0]   elem_data_q, elem_data_d;
  logic                mem_car_q, mem_car_d;
  logic                mem_cdr_q, mem_cdr_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    length_d     = length_q;
    elem_valid_d = elem_valid_q;
    elem_data_d  = elem_data_q;

    case (state_q)
      S_IDLE: begin
        // done_q high here means this is the done cycle; a coincident start is dropped
        if (start_i && !done_q) begin
          busy_d   = 1'b1;
          length_d = '0;
          if (head_i == NIL) begin
            state_d = S_FIN;
          end else begin
            ptr_d   = head_i;
            state_d = S_REQ_CAR;
          end
        end
      end
      S_REQ_CAR: state_d = S_GRD_CAR;
      S_GRD_CAR: state_d = S_WAIT_CAR;
      S_WAIT_CAR: begin
        if (mem_ready_i) begin
          elem_data_d  = mem_data_out_i;
          elem_valid_d = 1'b1;
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        if (elem_ready_i) begin
          elem_valid_d = 1'b0;
          if (length_q != '1) begin
            length_d = length_q + 1'b1;
          end
          state_d = S_REQ_CDR;
`ifdef LIST_WALKER_LEN_LIMIT_EN
          if ({1'b0, length_d} == LIMIT) begin
            state_d = S_FIN;
          end
`endif
        end
      end
      S_REQ_CDR: state_d = S_GRD_CDR;
      S_GRD_CDR: state_d = S_WAIT_CDR;
      S_WAIT_CDR: begin
        if (mem_ready_i) begin
          ptr_d   = mem_data_out_i;
          state_d = (mem_data_out_i == NIL) ? S_FIN : S_REQ_CAR;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef LIST_WALKER_LEN_LIMIT_EN
        error_d = ({1'b0, length_q} == LIMIT);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered off the next state so they coincide exactly with REQ_x
    mem_car_d  = (state_d == S_REQ_CAR);
    mem_cdr_d  = (state_d == S_REQ_CDR);
    mem_addr_d = (mem_car_d || mem_cdr_d) ? ptr_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      length_q     <= '0;
      elem_valid_q <= 1'b0;
      elem_data_q  <= '0;
      mem_car_q    <= 1'b0;
      mem_cdr_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      length_q     <= length_d;
      elem_valid_q <= elem_valid_d;
      elem_data_q  <= elem_data_d;
      mem_car_q    <= mem_car_d;
      mem_cdr_q    <= mem_cdr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign length_o      = length_q;
  assign elem_valid_o  = elem_valid_q;
  assign elem_data_o   = elem_data_q;
  assign mem_car_o     = mem_car_q;
  assign mem_cdr_o     = mem_cdr_q;
  assign mem_cons_o    = 1'b0;
  assign mem_data_in_o = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_list_walker.sv
// tb_list_walker: table-driven walks against a latency-3 memory model with an element scoreboard.
`default_nettype none

module tb_list_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] head_i = '0;
  logic        busy_o, done_o, error_o, elem_valid_o, mem_car_o, mem_cdr_o, mem_cons_o;
  logic [15:0] length_o;
  logic [23:0] elem_data_o, mem_data_in_o;
  logic        elem_ready_i = 1'b0;
  logic [23:0] mem_data_out_i = '0;
  logic        mem_ready_i = 1'b1;

  always #5 clk = ~clk;

  list_walker #(.DATA_W(24), .NIL(24'h000000), .LEN_W(16), .MAX_LEN(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .head_i(head_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .length_o(length_o),
    .elem_valid_o(elem_valid_o), .elem_data_o(elem_data_o), .elem_ready_i(elem_ready_i),
    .mem_car_o(mem_car_o), .mem_cdr_o(mem_cdr_o), .mem_cons_o(mem_cons_o),
    .mem_data_in_o(mem_data_in_o), .mem_data_out_i(mem_data_out_i), .mem_ready_i(mem_ready_i)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: ready drops the cycle after a strobe and returns 3 cycles after it
  logic [23:0] car_m [256];
  logic [23:0] cdr_m [256];
  logic [7:0]  rd_addr = '0;
  logic        rd_cdr = 1'b0;
  int          cnt_m = 0;

  always @(posedge clk) begin
    if (mem_car_o || mem_cdr_o) begin
      mem_ready_i <= 1'b0;
      cnt_m       <= 2;
      rd_addr     <= mem_data_in_o[7:0];
      rd_cdr      <= mem_cdr_o;
    end else if (cnt_m == 1) begin
      mem_ready_i    <= 1'b1;
      mem_data_out_i <= rd_cdr ? cdr_m[rd_addr] : car_m[rd_addr];
      cnt_m          <= 0;
    end else if (cnt_m > 0) begin
      cnt_m <= cnt_m - 1;
    end
  end

  // Consumer + scoreboard + port rule monitor
  logic [23:0] exp_q[$];
  int          stall = 0;
  int          stall_cnt = 0;
  int          car_cnt = 0;
  int          cdr_cnt = 0;
  int          hs_cnt = 0;
  int          viol = 0;
  bit          prev_stalled = 1'b0;
  logic [23:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_car_o && mem_cdr_o) viol++;
      if ((mem_car_o || mem_cdr_o) && elem_valid_o) viol++;
      if (!(mem_car_o || mem_cdr_o) && mem_data_in_o != 24'h0) viol++;
      if (mem_cons_o) viol++;
      if (mem_car_o) car_cnt++;
      if (mem_cdr_o) cdr_cnt++;
      if (elem_valid_o) begin
        if (prev_stalled) check("elem_data_stable", elem_data_o, prev_data);
        if (stall_cnt >= stall) begin
          elem_ready_i = 1'b1;
          hs_cnt++;
          stall_cnt    = 0;
          prev_stalled = 1'b0;
          if (exp_q.size() == 0) check("elem_unexpected", 32'd1, 32'd0);
          else check("elem_data", elem_data_o, exp_q.pop_front());
        end else begin
          elem_ready_i = 1'b0;
          stall_cnt++;
          prev_stalled = 1'b1;
          prev_data    = elem_data_o;
        end
      end else begin
        elem_ready_i = (stall == 0);
        prev_stalled = 1'b0;
      end
    end
  end

  task automatic run_walk(input logic [23:0] head, input int stall_v, input bit restart,
                          input int exp_len, input bit exp_err, input int exp_lat, input int cap);
    logic [23:0] p;
    int lat;
    bit seen;
    stall = stall_v; stall_cnt = 0; car_cnt = 0; cdr_cnt = 0; hs_cnt = 0; viol = 0;
    exp_q.delete();
    p = head;
    for (int i = 0; i < cap && p != 24'h0; i++) begin
      exp_q.push_back(car_m[p[7:0]]);
      p = cdr_m[p[7:0]];
    end
    @(negedge clk);
    start_i = 1'b1; head_i = head;
    lat = 0; seen = 1'b0;
    while (lat < 400 && !seen) begin
      @(negedge clk);
      lat++;
      start_i = restart && (lat == 5);
      head_i  = (restart && lat == 5) ? 24'h20 : head;
      if (lat == 1) check("busy_after_start", busy_o, 1);
      if (done_o) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("done_latency", lat, exp_lat);
    check("length", length_o, exp_len);
    check("error", error_o, exp_err);
    if (restart) begin
      start_i = 1'b1; head_i = 24'h10;
    end
    @(negedge clk);
    start_i = 1'b0;
    check("done_one_cycle", done_o, 0);
    check("busy_after_done", busy_o, 0);
    check("length_held", length_o, exp_len);
    repeat (4) @(negedge clk);
    check("car_strobes", car_cnt, exp_len);
    check("cdr_strobes", cdr_cnt, exp_err ? exp_len - 1 : exp_len);
    check("elements_taken", hs_cnt, exp_len);
    check("scoreboard_left", exp_q.size(), 0);
    check("port_rules", viol, 0);
  endtask

  typedef struct {
    logic [23:0] head;
    int          stall;
    bit          restart;
    int          exp_len;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    bit done_any;
    for (int i = 0; i < 256; i++) begin
      car_m[i] = 24'h0;
      cdr_m[i] = 24'h0;
    end
    car_m[8'h10] = 24'hA;  cdr_m[8'h10] = 24'h20;
    car_m[8'h20] = 24'hB;  cdr_m[8'h20] = 24'h30;
    car_m[8'h30] = 24'hC;  cdr_m[8'h30] = 24'h00;
    car_m[8'h40] = 24'h1;  cdr_m[8'h40] = 24'h40;

    // 2 + 9 cycles per element at memory latency 3, +stall per element
    vecs[0] = '{head: 24'h10, stall: 0, restart: 1'b0, exp_len: 3, exp_lat: 29};
    vecs[1] = '{head: 24'h00, stall: 0, restart: 1'b0, exp_len: 0, exp_lat: 2};
    vecs[2] = '{head: 24'h10, stall: 5, restart: 1'b0, exp_len: 3, exp_lat: 44};
    vecs[3] = '{head: 24'h10, stall: 0, restart: 1'b1, exp_len: 3, exp_lat: 29};
    vecs[4] = '{head: 24'h30, stall: 2, restart: 1'b0, exp_len: 1, exp_lat: 13};

    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_length", length_o, 0);
    check("rst_valid", elem_valid_o, 0);
    check("rst_strobes", {mem_car_o, mem_cdr_o, mem_cons_o}, 0);
    check("rst_addr", mem_data_in_o, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_walk(vecs[v].head, vecs[v].stall, vecs[v].restart, vecs[v].exp_len, 1'b0, vecs[v].exp_lat, 64);

    // Reset during WAIT_CDR of the second cell
    stall = 0; stall_cnt = 0; hs_cnt = 0;
    exp_q.delete();
    exp_q.push_back(24'hA); exp_q.push_back(24'hB); exp_q.push_back(24'hC);
    @(negedge clk);
    start_i = 1'b1; head_i = 24'h10;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      if (mem_cdr_o) n++;
    end
    check("second_cdr_seen", n, 2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_valid_data", {elem_valid_o, elem_data_o}, 0);
    check("midrst_length", length_o, 0);
    check("midrst_strobes", {mem_car_o, mem_cdr_o, done_o, error_o}, 0);
    check("midrst_addr", mem_data_in_o, 0);
    check("midrst_elems", hs_cnt, 2);
    check("midrst_left", exp_q.size(), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_walk(24'h20, 0, 1'b0, 2, 1'b0, 20, 64);

`ifdef LIST_WALKER_LEN_LIMIT_EN
    run_walk(24'h40, 0, 1'b0, 4, 1'b1, 34, 4);
`else
    stall = 0; stall_cnt = 0; hs_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(24'h1);
    @(negedge clk);
    start_i = 1'b1; head_i = 24'h40;
    @(negedge clk);
    start_i = 1'b0;
    done_any = 1'b0;
    for (int c = 0; c < 300 && hs_cnt < 6; c++) begin
      @(negedge clk);
      if (done_o) done_any = 1'b1;
    end
    check("loop_elements", hs_cnt, 6);
    check("loop_no_done", done_any, 0);
    check("loop_busy", busy_o, 1);
    check("loop_error", error_o, 0);
    #2 rst = 1'b0;
    #1;
    check("loop_rst_length", length_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
